// File: rtl/fft_input_loader_pkg.sv
// Shared definitions for the FFT input loader and address generators:
// loader state encoding and a width-generic bit-reverse helper.
package fft_input_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FULL  = 2'd2
  } ld_state_t;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      r[5'(i)] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Stream input, RAM port A and frame handshake of the FFT input loader.
// slave = loader view, master = producer/RAM/core view.
interface fft_input_loader_if #(
  parameter int unsigned DWL = 16,
  parameter int unsigned AWL = 8
);
  logic [DWL-1:0] i_DATA;
  logic           i_VALID;
  logic           i_LAST;
  logic           o_READY;
  logic           o_RAM_EN;
  logic           o_RAM_WrE;
  logic [AWL-1:0] o_RAM_ADDR;
  logic [DWL-1:0] o_RAM_DATA;
  logic           o_FRAME_RDY;
  logic           i_FRAME_ACK;
  logic           o_ERR_LAST;

  modport slave (
    input  i_DATA, i_VALID, i_LAST, i_FRAME_ACK,
    output o_READY, o_RAM_EN, o_RAM_WrE, o_RAM_ADDR, o_RAM_DATA, o_FRAME_RDY, o_ERR_LAST
  );

  modport master (
    output i_DATA, i_VALID, i_LAST, i_FRAME_ACK,
    input  o_READY, o_RAM_EN, o_RAM_WrE, o_RAM_ADDR, o_RAM_DATA, o_FRAME_RDY, o_ERR_LAST
  );
endinterface

// File: rtl/fft_bitrev_addr.sv
// Combinational sample-index to RAM-address mapping: bit-reversed or natural order.
module fft_bitrev_addr
  import fft_input_loader_pkg::*;
#(
  parameter int unsigned AWL         = 8,
  parameter bit          BIT_REVERSE = 1'b1
) (
  input  logic [AWL-1:0] idx,
  output logic [AWL-1:0] addr
);

  // Select reversed or pass-through index.
  always_comb begin
    addr = idx;
    if (BIT_REVERSE) begin
      addr = AWL'(bitrev(32'(idx), AWL));
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// Stream-to-RAM front end of the iterative FFT: writes one frame of 2**AWL
// samples into RAM port A, flags the frame to the core and waits for its ack.
module fft_input_loader
  import fft_input_loader_pkg::*;
#(
  parameter int unsigned DWL         = 16,
  parameter int unsigned AWL         = 8,
  parameter bit          BIT_REVERSE = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  fft_input_loader_if.slave    bus
);

  ld_state_t      state_q, state_d;
  logic [AWL-1:0] cnt_q;
  logic [AWL-1:0] wr_addr;
  logic           ready_q;
  logic           ram_en_q;
  logic [AWL-1:0] ram_addr_q;
  logic [DWL-1:0] ram_data_q;
  logic           frame_rdy_q;
  logic           err_q;
  logic           accept;
  logic           cnt_last;

  assign accept   = bus.i_VALID & ready_q;
  assign cnt_last = &cnt_q;

  fft_bitrev_addr #(
    .AWL         (AWL),
    .BIT_REVERSE (BIT_REVERSE)
  ) u_bitrev (
    .idx  (cnt_q),
    .addr (wr_addr)
  );

  // Next-state logic for the load / flush / full sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:  if (accept && cnt_last) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_FULL;
      ST_FULL:  if (bus.i_FRAME_ACK) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  // ready/frame-ready are decoded from the next state so they are registered
  // yet line up with the state they describe; ready stays low during reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      frame_rdy_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ready_q     <= (state_d == ST_LOAD);
      frame_rdy_q <= (state_d == ST_FULL);
      ram_en_q    <= accept;
      err_q       <= accept && (bus.i_LAST != cnt_last);
      if (accept) begin
        cnt_q      <= cnt_q + 1'b1;
        ram_addr_q <= wr_addr;
        ram_data_q <= bus.i_DATA;
      end
    end
  end

  assign bus.o_READY     = ready_q;
  assign bus.o_RAM_EN    = ram_en_q;
  assign bus.o_RAM_WrE   = ram_en_q;
  assign bus.o_RAM_ADDR  = ram_addr_q;
  assign bus.o_RAM_DATA  = ram_data_q;
  assign bus.o_FRAME_RDY = frame_rdy_q;
  assign bus.o_ERR_LAST  = err_q;

endmodule
